// File: rtl/sha256_msg_packer.sv
// Builds one padded SHA-256 block from a length-prefixed byte stream.
// Streams the block to the core as 16 big-endian words.
module sha256_msg_packer #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEAD_CYCLES = 3,
    parameter int MAX_LEN     = 55
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_dv_in,
    input  logic [7:0]            rx_byte_in,
    input  logic                  core_done_in,
    output logic                  MP_dv_out,
    output logic [4:0]            MP_counter_out,
    output logic [DATA_WIDTH-1:0] message_out,
    output logic                  busy_out,
    output logic                  err_out
);
    typedef enum logic [2:0] {IDLE, RECV, PAD, EMIT, WAIT_CORE} state_t;

    localparam logic [4:0] EMIT_LAST = 5'(LEAD_CYCLES + 15);

    state_t                state;
    logic [DATA_WIDTH-1:0] words_q [16];
    logic [7:0]            len_q;
    logic [5:0]            byte_cnt;
    logic [4:0]            emit_cnt;
    logic [3:0]            next_idx;
    logic [DATA_WIDTH-1:0] marker;
    int                    nxt;

    // Word 0 is held for LEAD_CYCLES extra cycles before the index advances.
    always_comb begin
        nxt      = int'(emit_cnt) + 1 - LEAD_CYCLES;
        next_idx = (nxt <= 0) ? 4'd0 : 4'(nxt);
    end

    assign marker = {{(DATA_WIDTH-8){1'b0}}, 8'h80} << {~len_q[1:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            words_q        <= '{default: '0};
            len_q          <= '0;
            byte_cnt       <= '0;
            emit_cnt       <= '0;
            MP_dv_out      <= 1'b0;
            MP_counter_out <= '0;
            message_out    <= '0;
            busy_out       <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            err_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv_in) begin
                        if (rx_byte_in > 8'(MAX_LEN)) begin
                            err_out <= 1'b1;
                        end else begin
                            len_q    <= rx_byte_in;
                            byte_cnt <= '0;
                            words_q  <= '{default: '0};
                            busy_out <= 1'b1;
                            state    <= (rx_byte_in == 8'd0) ? PAD : RECV;
                        end
                    end
                end
                RECV: begin
                    if (rx_dv_in) begin
                        // Lane 3 (MSB) holds the lowest byte address.
                        words_q[byte_cnt[5:2]][{~byte_cnt[1:0], 3'b000} +: 8] <= rx_byte_in;
                        byte_cnt <= byte_cnt + 6'd1;
                        if ({2'b00, byte_cnt} == len_q - 8'd1)
                            state <= PAD;
                    end
                end
                PAD: begin
                    if (rx_dv_in) err_out <= 1'b1;
                    // Bytes past L are already zero from the clear on entry.
                    words_q[len_q[5:2]] <= words_q[len_q[5:2]] | marker;
                    words_q[15]         <= {{(DATA_WIDTH-11){1'b0}}, len_q, 3'b000};
                    message_out         <= (len_q[5:2] == 4'd0) ? (words_q[0] | marker) : words_q[0];
                    MP_dv_out           <= 1'b1;
                    MP_counter_out      <= '0;
                    emit_cnt            <= '0;
                    state               <= EMIT;
                end
                EMIT: begin
                    if (rx_dv_in) err_out <= 1'b1;
                    if (emit_cnt == EMIT_LAST) begin
                        MP_dv_out      <= 1'b0;
                        MP_counter_out <= '0;
                        message_out    <= '0;
                        state          <= WAIT_CORE;
                    end else begin
                        emit_cnt       <= emit_cnt + 5'd1;
                        MP_counter_out <= {1'b0, next_idx};
                        message_out    <= words_q[next_idx];
                    end
                end
                WAIT_CORE: begin
                    if (rx_dv_in) err_out <= 1'b1;
                    if (core_done_in) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/sha256_msg_packer.md
Name: sha256_msg_packer

Overview:
- Upstream stage of the SHA-256 core. Receives a length-prefixed byte stream from the UART receiver and builds one padded 512-bit SHA-256 block (FIPS 180-4).
- Streams the block to the core as 16 big-endian 32-bit words with a word index.
- Timing is aligned to the core's 2-flop valid synchronizer and its 16-cycle load window.
- Single-block messages only: 0..55 bytes.

Parameters:
DATA_WIDTH, 32, word width to core; only 32 is supported.
LEAD_CYCLES, 3, extra cycles word 0 is held before the index starts advancing; covers the core's 2-flop sync plus its state transition.
MAX_LEN, 55, largest accepted message length in bytes.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
rx_dv_in  in  1  one-cycle strobe, rx_byte_in valid
rx_byte_in  in  8  byte from UART receiver
core_done_in  in  1  one-cycle pulse from the core when its hash transmit finishes (end of SEND_TX)
MP_dv_out  out  1  block valid, held high for the whole emit window
MP_counter_out  out  5  word index 0..15 of message_out
message_out  out  32  current block word, big-endian
busy_out  out  1  high in any state except IDLE
err_out  out  1  one-cycle pulse when a message is rejected

Behaviour:
- Reset: all outputs 0; state IDLE; buffer (16x32) cleared; byte and emit counters 0.
- All outputs are registered. No combinational path from input to output.
- States:
  - IDLE: on rx_dv_in, capture rx_byte_in as L.
    - L > MAX_LEN: pulse err_out for 1 cycle and stay IDLE. Following bytes are parsed as new length bytes.
    - L == 0: go to PAD.
    - Otherwise: go to RECV.
  - RECV: each rx_dv_in writes byte i (i = 0..L-1) into word i>>2, lane 3-(i&3). Lane 3 is bits[31:24], so the first byte is the MSB. After byte L-1 is written, go to PAD. Cycles without rx_dv_in hold state; there is no timeout.
  - PAD: single cycle. Byte L = 0x80. Bytes L+1..55 = 0x00. Word14 = 0. Word15 = L*8 (fits in 9 bits). Go to EMIT.
  - EMIT: lasts LEAD_CYCLES+16 cycles.
    - MP_dv_out = 1 throughout.
    - First LEAD_CYCLES+1 cycles: MP_counter_out = 0, message_out = word0.
    - Then one word per cycle, index 1..15.
    - After the cycle that presents word 15, MP_dv_out drops to 0 and the state goes to WAIT_CORE.
    - Net effect: the core's capture edges 4..19 after MP_dv_out rises see indices 0..15.
  - WAIT_CORE: hold until core_done_in, then go to IDLE. message_out and MP_counter_out return to 0.
- rx_dv_in in PAD, EMIT or WAIT_CORE: the byte is dropped and err_out pulses. The state is unchanged.
- core_done_in outside WAIT_CORE is ignored.
- rx_dv_in and core_done_in in the same cycle in WAIT_CORE: go to IDLE; the byte is dropped and err_out pulses.
- The buffer is zero-cleared on entry to RECV and on the IDLE-to-PAD transition, so stale bytes from the previous message never leak.
- rst_n asserted in any state, including mid-EMIT: outputs drop immediately (async) and the partial message is discarded. The core sees MP_dv_out fall.
- Byte counter is 6 bits and the length register is 8 bits. No wrap is possible because L <= 55 is enforced.

Test Plan:
- "abc": bytes 03 61 62 63 -> MP_dv_out high 19 cycles; index 0 for 4 cycles then 1..15; word0 = 0x61626380, words 1..14 = 0, word15 = 0x00000018.
- Empty message: byte 00 -> word0 = 0x80000000, all other words 0, word15 = 0x00000000; core hash out = e3b0c442...b855.
- Boundary: L = 55 with bytes 0x00..0x36 -> word13 = 0x34353680, word14 = 0, word15 = 0x000001B8. Then L = 56 -> err_out pulse, busy_out stays 0.
- Busy drop: send a byte during WAIT_CORE -> err_out pulse, no state change. After core_done_in, busy_out falls; the next message emits correctly.
- Reset mid-RECV, after 2 of 5 bytes: all outputs 0 at once. The next "abc" message yields exactly the vectors of the first scenario (no residue).
- End-to-end with the core, timing pinned: dv rise at edge E0 -> core stores index k on edge E0+4+k; digest "abc" = ba7816bf...f20015ad.
